// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline-stage registers: occupancy state codes
// and the default bubble instruction for the 32-bit instruction path.
package pipe_pkg;
  localparam logic [1:0] PS_EMPTY = 2'd0;
  localparam logic [1:0] PS_ONE   = 2'd1;
  localparam logic [1:0] PS_TWO   = 2'd2;

  // addi x0, x0, 0 -- canonical NOP used as the bubble on the instruction path
  localparam logic [31:0] PIPE_NOP = 32'h0000_0013;
endpackage

// File: rtl/pipe_dreg.sv
// WIDTH-bit data register with synchronous reset to RV and a load enable.
module pipe_dreg #(
  parameter int              WIDTH = 32,
  parameter logic [WIDTH-1:0] RV   = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Load d when enabled; reset returns the register to its bubble value.
  always_ff @(posedge clk) begin
    if (rst)     q <= RV;
    else if (en) q <= d;
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline-stage register with valid/ready handshake and a one-entry skid
// buffer. in_ready depends only on registered state (gated by ce), so a
// downstream stall never ripples combinationally into the upstream stage.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] FLUSH_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  logic [1:0]       state, state_nxt;
  logic             main_valid, skid_valid;
  logic             in_xfer, out_xfer;
  logic             main_ld, skid_ld;
  logic [WIDTH-1:0] main_d, skid_d, main_q, skid_q;

  assign main_valid = (state != PS_EMPTY);
  assign skid_valid = (state == PS_TWO);

  assign in_ready  = ce & ~skid_valid;
  assign out_valid = ce & main_valid;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  // Bubble value is forced when empty so debug views show a NOP, not stale data.
  assign out_data  = main_valid ? main_q : FLUSH_VAL;
  assign occupancy = state;

  // Next-state and payload-load selection; flush wins over every transfer.
  always_comb begin
    state_nxt = state;
    main_ld   = 1'b0;
    skid_ld   = 1'b0;
    main_d    = in_data;
    skid_d    = in_data;
    if (ce) begin
      if (flush) begin
        // Any same-cycle in_xfer is dropped; an out_xfer already consumed main.
        state_nxt = PS_EMPTY;
        main_ld   = 1'b1;
        skid_ld   = 1'b1;
        main_d    = FLUSH_VAL;
        skid_d    = FLUSH_VAL;
      end else begin
        case (state)
          PS_EMPTY: begin
            if (in_xfer) begin
              state_nxt = PS_ONE;
              main_ld   = 1'b1;
            end
          end
          PS_ONE: begin
            if (in_xfer && out_xfer) begin
              main_ld = 1'b1;
            end else if (in_xfer) begin
              state_nxt = PS_TWO;
              skid_ld   = 1'b1;
            end else if (out_xfer) begin
              state_nxt = PS_EMPTY;
            end
          end
          PS_TWO: begin
            // in_ready is low here, so only the drain path exists.
            if (out_xfer) begin
              state_nxt = PS_ONE;
              main_ld   = 1'b1;
              main_d    = skid_q;
            end
          end
          default: state_nxt = PS_EMPTY;
        endcase
      end
    end
  end

  // Occupancy state register; reset overrides ce and flush.
  always_ff @(posedge clk) begin
    if (rst) state <= PS_EMPTY;
    else     state <= state_nxt;
  end

  pipe_dreg #(.WIDTH(WIDTH), .RV(FLUSH_VAL)) u_main (
    .clk (clk),
    .rst (rst),
    .en  (main_ld),
    .d   (main_d),
    .q   (main_q)
  );

  pipe_dreg #(.WIDTH(WIDTH), .RV(FLUSH_VAL)) u_skid (
    .clk (clk),
    .rst (rst),
    .en  (skid_ld),
    .d   (skid_d),
    .q   (skid_q)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed tests on a 32-bit stage (bubble = PIPE_NOP) plus a randomized
// valid/ready run on an 8-bit stage against a reference FIFO model.
module tb_pipe_skid_reg;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst, ce, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [31:0] in_data, out_data;
  logic [1:0]  occupancy;

  logic        ce8, flush8, in_valid8, out_ready8, in_ready8, out_valid8;
  logic [7:0]  in_data8, out_data8;
  logic [1:0]  occupancy8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_skid_reg #(.WIDTH(32), .FLUSH_VAL(PIPE_NOP)) dut (
    .clk(clk), .rst(rst), .ce(ce), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  pipe_skid_reg #(.WIDTH(8), .FLUSH_VAL(8'h13)) dut8 (
    .clk(clk), .rst(rst), .ce(ce8), .flush(flush8),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
    .occupancy(occupancy8)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1; ce = 1; flush = 0; in_valid = 1; in_data = 32'h55; out_ready = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_checks++; if (out_data !== PIPE_NOP) begin n_fail++; $display("FAIL reset_out_data: got %h want %h", out_data, PIPE_NOP); end
      n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
    end
    rst = 0; in_valid = 0;
    step();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL reset_idle_occ: got %0d want 0", occupancy); end
  endtask

  task automatic test_streaming();
    out_ready = 1; in_valid = 1;
    for (int i = 1; i <= 4; i++) begin
      in_data = 32'(i);
      step();
      n_checks++; if (out_data !== 32'(i)) begin n_fail++; $display("FAIL stream_data%0d: got %h want %h", i, out_data, i); end
      n_checks++; if (out_valid !== 1'b1 || occupancy !== 2'd1) begin n_fail++; $display("FAIL stream_occ%0d: got v=%b occ=%0d want v=1 occ=1", i, out_valid, occupancy); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready%0d: got %b want 1", i, in_ready); end
    end
    in_valid = 0;
    step();
    n_checks++; if (occupancy !== 2'd0 || out_data !== PIPE_NOP) begin n_fail++; $display("FAIL stream_drain: got occ=%0d data=%h want occ=0 data=%h", occupancy, out_data, PIPE_NOP); end
  endtask

  task automatic test_backpressure();
    out_ready = 0; in_valid = 1; in_data = 32'hA;
    step();
    n_checks++; if (occupancy !== 2'd1 || out_data !== 32'hA) begin n_fail++; $display("FAIL bp_first: got occ=%0d data=%h want occ=1 data=a", occupancy, out_data); end
    in_data = 32'hB;
    step();
    n_checks++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL bp_occ2: got %0d want 2", occupancy); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
    // Offered while full: must not be captured.
    in_data = 32'hEE;
    step();
    n_checks++; if (occupancy !== 2'd2 || out_data !== 32'hA) begin n_fail++; $display("FAIL bp_hold: got occ=%0d data=%h want occ=2 data=a", occupancy, out_data); end
    in_valid = 0; out_ready = 1;
    n_checks++; if (out_valid !== 1'b1 || out_data !== 32'hA) begin n_fail++; $display("FAIL bp_deliver_a: got v=%b data=%h want v=1 data=a", out_valid, out_data); end
    step();
    n_checks++; if (out_data !== 32'hB || occupancy !== 2'd1) begin n_fail++; $display("FAIL bp_deliver_b: got data=%h occ=%0d want data=b occ=1", out_data, occupancy); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_back: got %b want 1", in_ready); end
    step();
    n_checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got occ=%0d v=%b want occ=0 v=0", occupancy, out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 0; in_valid = 1; in_data = 32'h21;
    step();
    in_data = 32'h22;
    step();
    flush = 1; in_data = 32'hC;
    step();
    n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL flush_occ: got %0d want 0", occupancy); end
    n_checks++; if (out_data !== PIPE_NOP || out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_data: got v=%b data=%h want v=0 data=%h", out_valid, out_data, PIPE_NOP); end
    // Flush while empty: the accepted in_xfer is dropped.
    in_data = 32'h77;
    step();
    flush = 0; in_valid = 0; out_ready = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin n_fail++; $display("FAIL flush_no_emit%0d: got v=%b occ=%0d want v=0 occ=0", i, out_valid, occupancy); end
    end
  endtask

  task automatic test_ce_hold();
    out_ready = 0; in_valid = 1; in_data = 32'h5;
    step();
    ce = 0; flush = 1; out_ready = 1; in_data = 32'h99;
    #1;
    n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL ce_gate: got r=%b v=%b want 0 0", in_ready, out_valid); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (occupancy !== 2'd1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL ce_hold%0d: got occ=%0d v=%b want occ=1 v=0", i, occupancy, out_valid); end
      n_checks++; if (out_data !== 32'h5) begin n_fail++; $display("FAIL ce_data%0d: got %h want 5", i, out_data); end
    end
    ce = 1; flush = 0; in_valid = 0;
    #1;
    n_checks++; if (out_valid !== 1'b1 || out_data !== 32'h5) begin n_fail++; $display("FAIL ce_resume: got v=%b data=%h want v=1 data=5", out_valid, out_data); end
    step();
    n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL ce_drained: got %0d want 0", occupancy); end
  endtask

  task automatic test_reset_mid();
    out_ready = 0; in_valid = 1; in_data = 32'h31;
    step();
    in_data = 32'h32;
    step();
    rst = 1; ce = 0; flush = 0;
    step();
    n_checks++; if (occupancy !== 2'd0 || out_data !== PIPE_NOP) begin n_fail++; $display("FAIL rst_mid: got occ=%0d data=%h want occ=0 data=%h", occupancy, out_data, PIPE_NOP); end
    rst = 0; ce = 1; in_valid = 0; out_ready = 1;
    step();
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_idle: got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    logic [7:0] exp_data;
    logic       ix, ox;
    int         pushes = 0, pops = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      in_valid8  = 1'($urandom_range(0, 1));
      out_ready8 = 1'($urandom_range(0, 1));
      in_data8   = 8'($urandom);
      flush8     = ($urandom_range(0, 24) == 0);
      #1;
      exp_data = (q.size() > 0) ? q[0] : 8'h13;
      n_checks++; if (occupancy8 !== 2'(q.size())) begin n_fail++; $display("FAIL rnd_occ c%0d: got %0d want %0d", cyc, occupancy8, q.size()); end
      n_checks++; if (in_ready8 !== (q.size() < 2) || out_valid8 !== (q.size() > 0)) begin n_fail++; $display("FAIL rnd_hs c%0d: got r=%b v=%b want r=%b v=%b", cyc, in_ready8, out_valid8, q.size() < 2, q.size() > 0); end
      n_checks++; if (out_data8 !== exp_data) begin n_fail++; $display("FAIL rnd_data c%0d: got %h want %h", cyc, out_data8, exp_data); end
      ix = in_valid8 && (q.size() < 2);
      ox = out_ready8 && (q.size() > 0);
      if (ox) begin void'(q.pop_front()); pops++; end
      if (flush8) q.delete();
      else if (ix) begin q.push_back(in_data8); pushes++; end
      step();
    end
    in_valid8 = 0; flush8 = 0; out_ready8 = 1;
    step(); step();
    n_checks++; if (occupancy8 !== 2'd0 || pops == 0 || pushes == 0) begin n_fail++; $display("FAIL rnd_final: got occ=%0d pushes=%0d pops=%0d want occ=0 and traffic", occupancy8, pushes, pops); end
  endtask

  initial begin
    ce8 = 1; flush8 = 0; in_valid8 = 0; out_ready8 = 0; in_data8 = '0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_ce_hold();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
